// File: rtl/int_issue_queue_pkg.sv
// Shared types and constants for the integer issue queue.
//   cdb_bus     : common data bus broadcast (data, tag, valid, branch info)
//   iq_entry_t  : one issue-queue slot (valid, uop fields, two operands, rd tag)
//   R_TYPE/I_TYPE/B_TYPE : integer/branch opcode constants
//   tag_hit()   : operand wakeup match against the CDB
package int_issue_queue_pkg;

  // Default physical/ROB tag width; the CDB and the entry struct are sized by it.
  localparam int IQ_TAG_W = 6;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  typedef struct packed {
    logic [31:0]         cdb_data;
    logic [IQ_TAG_W-1:0] cdb_tag;
    logic                cdb_valid;
    logic                cdb_branch;
    logic                cdb_branch_taken;
  } cdb_bus;

  typedef struct packed {
    logic                valid;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         rs1_data;
    logic [IQ_TAG_W-1:0] rs1_tag;
    logic                rs1_rdy;
    logic [31:0]         rs2_data;
    logic [IQ_TAG_W-1:0] rs2_tag;
    logic                rs2_rdy;
    logic [IQ_TAG_W-1:0] rd_tag;
  } iq_entry_t;

  // A pending operand is woken only by a valid result broadcast; branch-only
  // broadcasts carry cdb_valid=0 and never match.
  function automatic logic tag_hit(input logic rdy, input logic [IQ_TAG_W-1:0] tag,
                                   input cdb_bus cdb);
    return !rdy && cdb.cdb_valid && (cdb.cdb_tag == tag);
  endfunction

endpackage

// File: rtl/int_issue_queue_select.sv
// Oldest-ready priority picker for the integer issue queue.
// Ports:
//   ready  in  DEPTH  per-entry "both operands ready" (index 0 = oldest)
//   grant  out DEPTH  one-hot grant of the lowest-index ready entry
//   idx    out IDX_W  binary index of the granted entry
//   any    out 1      at least one entry is ready
// Purely combinational; the caller decides whether the grant is used.
module iq_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Scan from the youngest down so the oldest ready entry is the last to win.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue (reservation station) for the out-of-order core.
// Collapsing queue: index 0 is the oldest entry and valid entries are always
// contiguous from index 0. Each cycle the oldest entry with both operands
// ready (registered state) is issued through registered outputs, entries
// above it shift down, and a dispatched uop is appended behind the survivors.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 clears all entries; discards same-cycle dispatch/issue
//   dispatch_en, disp_*   one uop written per cycle (operand value or pending tag)
//   cdb_in                CDB broadcast used for wakeup and dispatch bypass
//   issue_allow           integer unit owns the CDB slot, selection permitted
//   queue_full/count      occupancy (count registered, full derived from it)
//   issue_int, iss_*      registered issue strobe and uop fields to the exec unit
// TAG_W must equal the package IQ_TAG_W; the CDB and entry types are sized by it.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IQ_TAG_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_en,
  input  logic [6:0]       disp_opcode,
  input  logic [2:0]       disp_funct3,
  input  logic [6:0]       disp_funct7,
  input  logic [31:0]      disp_rs1_data,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic             disp_rs1_rdy,
  input  logic [31:0]      disp_rs2_data,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             disp_rs2_rdy,
  input  logic [TAG_W-1:0] disp_rd_tag,
  input  cdb_bus           cdb_in,
  input  logic             issue_allow,
  output logic             queue_full,
  output logic [CNT_W-1:0] queue_count,
  output logic             issue_int,
  output logic [6:0]       iss_opcode,
  output logic [2:0]       iss_funct3,
  output logic [6:0]       iss_funct7,
  output logic [31:0]      iss_rs1,
  output logic [31:0]      iss_rs2,
  output logic [TAG_W-1:0] iss_rd_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        entry_q [DEPTH];
  iq_entry_t        entry_d [DEPTH];
  iq_entry_t        woken   [DEPTH];
  iq_entry_t        new_entry;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_after;
  logic             disp_ok;

  logic             issue_int_q, issue_int_d;
  logic [6:0]       iss_opcode_q, iss_opcode_d;
  logic [2:0]       iss_funct3_q, iss_funct3_d;
  logic [6:0]       iss_funct7_q, iss_funct7_d;
  logic [31:0]      iss_rs1_q, iss_rs1_d;
  logic [31:0]      iss_rs2_q, iss_rs2_d;
  logic [TAG_W-1:0] iss_rd_tag_q, iss_rd_tag_d;

  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] sel_grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             issued;

  // Branch resolution fields of the CDB are consumed elsewhere in the core.
  logic unused_cdb;
  assign unused_cdb = cdb_in.cdb_branch ^ cdb_in.cdb_branch_taken;

  // Wakeup of stored entries, and eligibility from registered readiness only,
  // so a CDB capture makes an entry selectable one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entry_q[i];
      if (entry_q[i].valid && tag_hit(entry_q[i].rs1_rdy, entry_q[i].rs1_tag, cdb_in)) begin
        woken[i].rs1_data = cdb_in.cdb_data;
        woken[i].rs1_rdy  = 1'b1;
      end
      if (entry_q[i].valid && tag_hit(entry_q[i].rs2_rdy, entry_q[i].rs2_tag, cdb_in)) begin
        woken[i].rs2_data = cdb_in.cdb_data;
        woken[i].rs2_rdy  = 1'b1;
      end
      ready_vec[i] = entry_q[i].valid && entry_q[i].rs1_rdy && entry_q[i].rs2_rdy;
    end
  end

  iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready (ready_vec),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign issued = issue_allow && !flush && sel_any;

  // New entry, with same-cycle CDB bypass for pending operands.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.opcode   = disp_opcode;
    new_entry.funct3   = disp_funct3;
    new_entry.funct7   = disp_funct7;
    new_entry.rs1_tag  = disp_rs1_tag;
    new_entry.rs2_tag  = disp_rs2_tag;
    new_entry.rd_tag   = disp_rd_tag;
    new_entry.rs1_data = disp_rs1_data;
    new_entry.rs1_rdy  = disp_rs1_rdy;
    new_entry.rs2_data = disp_rs2_data;
    new_entry.rs2_rdy  = disp_rs2_rdy;
    if (tag_hit(disp_rs1_rdy, disp_rs1_tag, cdb_in)) begin
      new_entry.rs1_data = cdb_in.cdb_data;
      new_entry.rs1_rdy  = 1'b1;
    end
    if (tag_hit(disp_rs2_rdy, disp_rs2_tag, cdb_in)) begin
      new_entry.rs2_data = cdb_in.cdb_data;
      new_entry.rs2_rdy  = 1'b1;
    end
  end

  // Collapse, append and flush.
  always_comb begin
    // Occupancy once the issuing entry has left; the new uop goes right there.
    cnt_after = count_q - CNT_W'(issued);
    disp_ok   = dispatch_en && (cnt_after != CNT_W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (issued && (IDX_W'(i) >= sel_idx)) begin
        entry_d[i] = woken[(i < DEPTH - 1) ? i + 1 : i];
        if (i == DEPTH - 1) entry_d[i].valid = 1'b0;
      end else begin
        entry_d[i] = woken[i];
      end
      if (disp_ok && (cnt_after == CNT_W'(i))) entry_d[i] = new_entry;
      if (flush) entry_d[i].valid = 1'b0;
    end
    count_d = flush ? '0 : cnt_after + CNT_W'(disp_ok);
  end

  // Issue register load: one-hot AND-OR of the granted entry; hold otherwise.
  always_comb begin
    issue_int_d  = issued;
    iss_opcode_d = iss_opcode_q;
    iss_funct3_d = iss_funct3_q;
    iss_funct7_d = iss_funct7_q;
    iss_rs1_d    = iss_rs1_q;
    iss_rs2_d    = iss_rs2_q;
    iss_rd_tag_d = iss_rd_tag_q;
    if (issued) begin
      iss_opcode_d = '0;
      iss_funct3_d = '0;
      iss_funct7_d = '0;
      iss_rs1_d    = '0;
      iss_rs2_d    = '0;
      iss_rd_tag_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_grant[i]) begin
          iss_opcode_d = iss_opcode_d | entry_q[i].opcode;
          iss_funct3_d = iss_funct3_d | entry_q[i].funct3;
          iss_funct7_d = iss_funct7_d | entry_q[i].funct7;
          iss_rs1_d    = iss_rs1_d    | entry_q[i].rs1_data;
          iss_rs2_d    = iss_rs2_d    | entry_q[i].rs2_data;
          iss_rd_tag_d = iss_rd_tag_d | entry_q[i].rd_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q      <= '0;
      issue_int_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_funct3_q <= '0;
      iss_funct7_q <= '0;
      iss_rs1_q    <= '0;
      iss_rs2_q    <= '0;
      iss_rd_tag_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      count_q      <= count_d;
      issue_int_q  <= issue_int_d;
      iss_opcode_q <= iss_opcode_d;
      iss_funct3_q <= iss_funct3_d;
      iss_funct7_q <= iss_funct7_d;
      iss_rs1_q    <= iss_rs1_d;
      iss_rs2_q    <= iss_rs2_d;
      iss_rd_tag_q <= iss_rd_tag_d;
    end
  end

  assign queue_count = count_q;
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign issue_int   = issue_int_q;
  assign iss_opcode  = iss_opcode_q;
  assign iss_funct3  = iss_funct3_q;
  assign iss_funct7  = iss_funct7_q;
  assign iss_rs1     = iss_rs1_q;
  assign iss_rs2     = iss_rs2_q;
  assign iss_rd_tag  = iss_rd_tag_q;

  // The dispatcher stalls on queue_full; a uop arriving anyway is lost.
  a_no_drop: assert property (@(posedge clk) disable iff (rst)
    !(dispatch_en && queue_full && !issued && !flush))
    else $warning("int_issue_queue: dispatch dropped while queue full");

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Reservation station / issue queue feeding the integer execution unit in the Tomasulo-style out-of-order core.
- Accepts dispatched integer and branch uops with operand values or pending tags.
- Snoops the CDB to wake up pending operands.
- Issues the oldest fully-ready entry per cycle via registered outputs that drive the integer exec unit directly (issue_int, Opcode, Funct3, Funct7, RS1, RS2, RD_Tag).

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 6, physical/ROB tag width; matches CDB tag width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  mispredict flush; clears all entries.
- dispatch_en  in  1  write one uop this cycle.
- disp_opcode  in  7  uop opcode.
- disp_funct3  in  3  uop funct3.
- disp_funct7  in  7  uop funct7.
- disp_rs1_data  in  32  rs1 value (valid when disp_rs1_rdy).
- disp_rs1_tag  in  TAG_W  rs1 producer tag.
- disp_rs1_rdy  in  1  rs1 value already available.
- disp_rs2_data / disp_rs2_tag / disp_rs2_rdy  in  32/TAG_W/1  same for rs2.
- disp_rd_tag  in  TAG_W  destination tag.
- cdb_in  in  cdb_bus  CDB broadcast (cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken).
- issue_allow  in  1  CDB slot granted to integer unit this cycle.
- queue_full  out  1  all DEPTH entries valid.
- queue_count  out  CNT_W  valid entries.
- issue_int  out  1  registered issue strobe to exec unit.
- iss_opcode  out  7  registered opcode.
- iss_funct3  out  3  registered funct3.
- iss_funct7  out  7  registered funct7.
- iss_rs1  out  32  registered rs1 value.
- iss_rs2  out  32  registered rs2 value.
- iss_rd_tag  out  TAG_W  registered destination tag.

Behaviour:
- Reset (async, rst=1): all entry valid bits 0; queue_full=0; queue_count=0; issue_int=0; all iss_* = 0. Entry payload need not be reset.
- Storage: collapsing queue. Index 0 is the oldest. Valid entries are always contiguous from index 0.
- Wakeup: each clock, any valid entry whose operand is not ready and whose tag == cdb_in.cdb_tag while cdb_in.cdb_valid=1 captures cdb_in.cdb_data and sets that operand ready. cdb_branch-only broadcasts (cdb_valid=0) wake nothing.
- Dispatch bypass: if disp_rsX_rdy=0 and the CDB matches disp_rsX_tag in the dispatch cycle, the entry is written with the CDB data and marked ready.
- Select: the lowest-index entry with both operands ready (registered state; a CDB capture makes an entry eligible the following cycle). Selection happens only when issue_allow=1 and flush=0.
- Issue: at the edge where an entry is selected, its fields load into iss_*, issue_int=1 for the next cycle, and entries above it shift down one index. With no selection, issue_int=0 next cycle and iss_* hold their values.
- Dispatch write: the new entry lands at index (queue_count − issued), so it sits behind all remaining entries.
- Latency: dispatch with both operands ready in cycle 0 → eligible in cycle 1 → issue_int=1 in cycle 2 (given issue_allow).
- Full: queue_full = (queue_count == DEPTH). A dispatch while full with no issue that cycle is dropped. Dispatch while full with an issue in the same cycle is accepted. The dispatcher must stall on queue_full; an assertion flags a drop.
- Simultaneous issue+dispatch: count unchanged; ordering is preserved.
- Flush: highest priority. At the edge, all valid bits clear, count=0, issue_int=0, and the same-cycle dispatch and issue are discarded.
- Reset mid-operation clears everything immediately, with no partial issue.
- queue_count is the registered count; queue_full is derived combinationally from it.

Decomposition:
- Shared package (variables): cdb_bus typedef, opcode constants (R_TYPE, I_TYPE, B_TYPE), TAG_W default, and a new iq_entry_t struct (valid, opcode, funct3, funct7, rs1/rs2 data/tag/rdy, rd_tag).
- Sub-module: iq_select, a combinational oldest-ready priority picker that outputs a one-hot grant and an index.
- The top instantiates int_exec_unit downstream; this block does not.

Test Plan:
- Reset then dispatch ADD (opcode 0110011, f3=0, f7=0) with rs1=5 and rs2=7 ready, issue_allow=1 → issue_int=1 two cycles later with iss_rs1=5, iss_rs2=7 and the correct rd_tag; count returns to 0.
- Dispatch uop with rs1 pending tag 0x12; next cycle CDB tag 0x12, valid, data 0xDEADBEEF → issue the following cycle with iss_rs1=0xDEADBEEF; a CDB with the same tag but valid=0 must not wake it.
- Dispatch in the same cycle the CDB broadcasts its pending tag (bypass) → entry ready immediately and issued at cycle 2.
- Fill 4 entries with issue_allow=0 → queue_full=1, count=4. A 5th dispatch is dropped and the assertion fires. Set issue_allow=1 → issues follow index order 0..3 (oldest first), with entries shifting down.
- Entries 0 (not ready) and 1 (ready) → entry 1 issues first; entry 0 moves to index 0, and a simultaneous dispatch lands at index 1.
- Flush asserted with 3 entries, a dispatch and an issue in the same cycle → next cycle count=0, issue_int=0, and nothing later issues. Async rst mid-stream clears all outputs without waiting for a clock edge.
